// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier function codes and the sequencer state type.
// Used by seq_mul_unit (optional macro SEQ_MUL_EARLY_TERM_EN lives in the multiplier files).
package alu_pkg;

  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] MULT  = 6'b011000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } seq_mul_state_e;

  function automatic logic isMulCode(input logic [5:0] code);
    return (code == MULTU) || (code == MULT);
  endfunction

endpackage

// File: rtl/seq_mul_unit_if.sv
// Request/response bundle between the control unit and the sequential multiplier.
interface seq_mul_unit_if #(
  parameter int WIDTH = 32
);

  logic                 start;
  logic [5:0]           Signal;
  logic [WIDTH-1:0]     dataA;
  logic [WIDTH-1:0]     dataB;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   dataOut;

  modport master (
    output start, Signal, dataA, dataB,
    input  busy, done, dataOut
  );

  modport slave (
    input  start, Signal, dataA, dataB,
    output busy, done, dataOut
  );

endinterface

// File: rtl/seq_mul_datapath.sv
// Shift-add datapath: product/multiplicand/multiplier registers, adder and right shifter.
// With SEQ_MUL_EARLY_TERM_EN the final step also applies all remaining shifts at once.
module seq_mul_datapath #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic                 i_step,
  input  logic [WIDTH-1:0]     i_mcand,
  input  logic [WIDTH-1:0]     i_mult,
  input  logic [CNT_W-1:0]     i_count,
  output logic [2*WIDTH-1:0]   o_product,
  output logic                 o_lastStep
);

  logic [2*WIDTH-1:0] r_product;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mult;

  logic [WIDTH:0]     w_sum;
  logic [CNT_W-1:0]   w_extra;
  logic [CNT_W-1:0]   w_shamt;
  logic [2*WIDTH-1:0] w_shifted;

`ifdef SEQ_MUL_EARLY_TERM_EN
  logic w_restZero;
  // Once no multiplier bits remain, the outstanding iterations are pure shifts.
  assign w_restZero = (r_mult[WIDTH-1:1] == '0);
  assign w_extra    = w_restZero ? (CNT_W'(WIDTH - 1) - i_count) : '0;
  assign o_lastStep = w_restZero || (i_count == CNT_W'(WIDTH - 1));
`else
  assign w_extra    = '0;
  assign o_lastStep = (i_count == CNT_W'(WIDTH - 1));
`endif

  assign w_sum     = r_mult[0] ? ({1'b0, r_product[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand})
                               : {1'b0, r_product[2*WIDTH-1:WIDTH]};
  assign w_shamt   = w_extra + CNT_W'(1);
  assign w_shifted = (2*WIDTH)'({w_sum, r_product[WIDTH-1:0]} >> w_shamt);
  assign o_product = r_product;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_product <= '0;
      r_mcand   <= '0;
      r_mult    <= '0;
    end else if (i_load) begin
      r_product <= '0;
      r_mcand   <= i_mcand;
      r_mult    <= i_mult;
    end else if (i_step) begin
      r_product <= w_shifted;
      r_mult    <= r_mult >> 1;
    end
  end

endmodule

// File: rtl/seq_mul_unit.sv
// Sequential signed/unsigned multiplier with start/busy/done handshake and held result.
// Optional macro SEQ_MUL_EARLY_TERM_EN ends the RUN phase once the multiplier is exhausted.
module seq_mul_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic           clk,
  input  logic           reset,
  seq_mul_unit_if.slave  bus
);

  seq_mul_state_e     r_state;
  logic [CNT_W-1:0]   r_count;
  logic               r_neg;
  logic               r_busy;
  logic               r_done;
  logic [2*WIDTH-1:0] r_dataOut;

  logic               w_isMult;
  logic               w_accept;
  logic               w_load;
  logic               w_step;
  logic               w_negIn;
  logic               w_lastStep;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic [2*WIDTH-1:0] w_product;

  assign w_isMult = (bus.Signal == MULT);
  assign w_accept = (r_state == IDLE) && bus.start && isMulCode(bus.Signal);
  assign w_load   = w_accept;
  assign w_step   = (r_state == RUN);

  // Signed mode multiplies magnitudes; the most-negative value's magnitude still fits unsigned.
  assign w_absA  = (w_isMult && bus.dataA[WIDTH-1]) ? -bus.dataA : bus.dataA;
  assign w_absB  = (w_isMult && bus.dataB[WIDTH-1]) ? -bus.dataB : bus.dataB;
  assign w_negIn = w_isMult && (bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1]);

  seq_mul_datapath #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_datapath (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_mcand    (w_absA),
    .i_mult     (w_absB),
    .i_count    (r_count),
    .o_product  (w_product),
    .o_lastStep (w_lastStep)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_neg     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dataOut <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= RUN;
            r_count <= '0;
            r_neg   <= w_negIn;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          r_count <= r_count + CNT_W'(1);
          if (w_lastStep) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_dataOut <= r_neg ? -w_product : w_product;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.dataOut = r_dataOut;

endmodule

// File: tb/tb_seq_mul_unit.sv
// Self-checking bench for seq_mul_unit at WIDTH=32 and WIDTH=8 against an arithmetic reference.
// Exact-latency checks are skipped when SEQ_MUL_EARLY_TERM_EN is defined.
module tb_seq_mul_unit;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   nCompared   = 0;
  int   nMismatched = 0;

  seq_mul_unit_if #(.WIDTH(32)) bus32 ();
  seq_mul_unit_if #(.WIDTH(8))  bus8 ();

  seq_mul_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));
  seq_mul_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));

  always #5 clk = ~clk;

  function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint pa;
    longint pb;
    if (s) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      return pa * pb;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input bit s);
    int pa;
    int pb;
    int pr;
    if (s) begin
      pa = int'($signed(a));
      pb = int'($signed(b));
    end else begin
      pa = int'({24'd0, a});
      pb = int'({24'd0, b});
    end
    pr = pa * pb;
    return pr[15:0];
  endfunction

  // Starts one 32-bit op and waits for done, scrambling the operand inputs while busy.
  task automatic runOp32(input logic [31:0] a, input logic [31:0] b, input logic [5:0] sig,
                         output logic [63:0] res, output int lat, output bit ok);
    @(negedge clk);
    bus32.start  = 1'b1;
    bus32.Signal = sig;
    bus32.dataA  = a;
    bus32.dataB  = b;
    @(posedge clk);
    lat = 0;
    ok  = 1'b0;
    @(negedge clk);
    bus32.start = 1'b0;
    while (lat < 100 && !ok) begin
      bus32.dataA  = $urandom;
      bus32.dataB  = $urandom;
      bus32.Signal = 6'($urandom);
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus32.done) ok = 1'b1;
    end
    res = bus32.dataOut;
  endtask

  task automatic runOp8(input logic [7:0] a, input logic [7:0] b, input logic [5:0] sig,
                        output logic [15:0] res, output int lat, output bit ok);
    @(negedge clk);
    bus8.start  = 1'b1;
    bus8.Signal = sig;
    bus8.dataA  = a;
    bus8.dataB  = b;
    @(posedge clk);
    lat = 0;
    ok  = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    while (lat < 40 && !ok) begin
      bus8.dataA = 8'($urandom);
      bus8.dataB = 8'($urandom);
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus8.done) ok = 1'b1;
    end
    res = bus8.dataOut;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    nCompared++;
    if (bus32.busy !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_busy32: got %b expected 0", bus32.busy);
    end
    nCompared++;
    if (bus32.done !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_done32: got %b expected 0", bus32.done);
    end
    nCompared++;
    if (bus32.dataOut !== 64'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_dataOut32: got %h expected 0", bus32.dataOut);
    end
    nCompared++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.dataOut !== 16'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_state8: got busy=%b done=%b dataOut=%h expected 0/0/0",
               bus8.busy, bus8.done, bus8.dataOut);
    end
    reset = 1'b1;
  endtask

  task automatic test_multu_basic();
    logic [63:0] res;
    int lat;
    bit ok;
    runOp32(32'd3, 32'd5, MULTU, res, lat, ok);
    nCompared++;
    if (!ok) begin
      nMismatched++;
      $display("[TB] FAIL basic_timeout: done seen=%b expected 1", ok);
    end
`ifndef SEQ_MUL_EARLY_TERM_EN
    nCompared++;
    if (lat != 33) begin
      nMismatched++;
      $display("[TB] FAIL basic_latency: got %0d expected 33", lat);
    end
`endif
    nCompared++;
    if (res !== 64'd15) begin
      nMismatched++;
      $display("[TB] FAIL basic_result: got %h expected %h", res, 64'd15);
    end
    nCompared++;
    if (bus32.busy !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL basic_busy_after: got %b expected 0", bus32.busy);
    end
  endtask

  task automatic test_signed_corners();
    logic [31:0] va [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0};
    logic [31:0] vb [6] = '{32'd6, 32'd6, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    logic [5:0]  vs [6] = '{MULT, MULTU, MULTU, MULT, MULT, MULT};
    logic [63:0] ve [6] = '{64'hFFFF_FFFF_FFFF_FFD6, 64'h0000_0005_FFFF_FFD6, 64'hFFFF_FFFE_0000_0001,
                            64'h4000_0000_0000_0000, 64'hC000_0000_8000_0000, 64'h0};
    logic [63:0] res;
    int lat;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      runOp32(va[i], vb[i], vs[i], res, lat, ok);
      nCompared++;
      if (!ok || res !== ve[i]) begin
        nMismatched++;
        $display("[TB] FAIL corner%0d: got %h (done=%b) expected %h", i, res, ok, ve[i]);
      end
    end
  endtask

  // Ends on the negedge where done is high so the next op can start in the done cycle.
  task automatic test_ignore_busy();
    int lat = 0;
    bit ok = 1'b0;
    @(negedge clk);
    bus32.start  = 1'b1;
    bus32.Signal = MULTU;
    bus32.dataA  = 32'd2;
    bus32.dataB  = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus32.start = 1'b0;
    while (lat < 100 && !ok) begin
      if (lat == 10) begin
        bus32.start = 1'b1;
        bus32.dataA = 32'd9;
        bus32.dataB = 32'd9;
      end else begin
        bus32.start = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus32.done) ok = 1'b1;
    end
    nCompared++;
    if (!ok || bus32.dataOut !== 64'd6) begin
      nMismatched++;
      $display("[TB] FAIL ignore_result: got %h (done=%b) expected %h", bus32.dataOut, ok, 64'd6);
    end
`ifndef SEQ_MUL_EARLY_TERM_EN
    nCompared++;
    if (lat != 33) begin
      nMismatched++;
      $display("[TB] FAIL ignore_latency: got %0d expected 33", lat);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int lat = 0;
    int extraDone = 0;
    bit ok = 1'b0;
    bus32.start  = 1'b1;
    bus32.Signal = MULTU;
    bus32.dataA  = 32'd4;
    bus32.dataB  = 32'd4;
    @(posedge clk);
    @(negedge clk);
    bus32.start = 1'b0;
    nCompared++;
    if (bus32.busy !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL b2b_accept: busy got %b expected 1", bus32.busy);
    end
    while (lat < 100 && !ok) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus32.done) ok = 1'b1;
    end
    nCompared++;
    if (!ok || bus32.dataOut !== 64'd16) begin
      nMismatched++;
      $display("[TB] FAIL b2b_result: got %h (done=%b) expected %h", bus32.dataOut, ok, 64'd16);
    end
`ifndef SEQ_MUL_EARLY_TERM_EN
    nCompared++;
    if (lat != 33) begin
      nMismatched++;
      $display("[TB] FAIL b2b_latency: got %0d expected 33", lat);
    end
`endif
    repeat (40) begin
      @(negedge clk);
      if (bus32.done) extraDone++;
    end
    nCompared++;
    if (extraDone != 0) begin
      nMismatched++;
      $display("[TB] FAIL single_done: got %0d extra dones expected 0", extraDone);
    end
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    int busies = 0;
    @(negedge clk);
    bus32.start  = 1'b1;
    bus32.Signal = MULT;
    bus32.dataA  = 32'd1234;
    bus32.dataB  = 32'd5678;
    @(posedge clk);
    @(negedge clk);
    bus32.start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b0;
    #1;
    nCompared++;
    if (bus32.busy !== 1'b0 || bus32.done !== 1'b0 || bus32.dataOut !== 64'd0) begin
      nMismatched++;
      $display("[TB] FAIL abort_clear: got busy=%b done=%b dataOut=%h expected 0/0/0",
               bus32.busy, bus32.done, bus32.dataOut);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (bus32.done) dones++;
      if (bus32.busy) busies++;
    end
    nCompared++;
    if (dones != 0 || busies != 0) begin
      nMismatched++;
      $display("[TB] FAIL abort_no_done: got dones=%0d busyCycles=%0d expected 0/0", dones, busies);
    end
  endtask

  task automatic test_bad_code();
    int dones = 0;
    int busies = 0;
    @(negedge clk);
    bus32.start  = 1'b1;
    bus32.Signal = 6'b100000;
    bus32.dataA  = 32'd7;
    bus32.dataB  = 32'd7;
    @(posedge clk);
    @(negedge clk);
    bus32.start = 1'b0;
    if (bus32.busy) busies++;
    repeat (40) begin
      @(negedge clk);
      if (bus32.done) dones++;
      if (bus32.busy) busies++;
    end
    nCompared++;
    if (dones != 0 || busies != 0 || bus32.dataOut !== 64'd0) begin
      nMismatched++;
      $display("[TB] FAIL bad_code: got dones=%0d busyCycles=%0d dataOut=%h expected 0/0/0",
               dones, busies, bus32.dataOut);
    end
  endtask

  task automatic test_width8();
    logic [15:0] res;
    int lat;
    bit ok;
    runOp8(8'h80, 8'h7F, MULT, res, lat, ok);
    nCompared++;
    if (!ok || res !== 16'hC080) begin
      nMismatched++;
      $display("[TB] FAIL w8_result: got %h (done=%b) expected c080", res, ok);
    end
`ifndef SEQ_MUL_EARLY_TERM_EN
    nCompared++;
    if (lat != 9) begin
      nMismatched++;
      $display("[TB] FAIL w8_latency: got %0d expected 9", lat);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] a32;
    logic [31:0] b32;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [63:0] res32;
    logic [15:0] res8;
    logic [63:0] exp32;
    logic [15:0] exp8;
    bit s;
    int lat;
    bit ok;
    for (int i = 0; i < 500; i++) begin
      s = 1'($urandom);
      case ($urandom_range(0, 7))
        0:       a32 = 32'h8000_0000;
        1:       a32 = 32'hFFFF_FFFF;
        2:       a32 = $urandom_range(0, 15);
        default: a32 = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b32 = 32'h8000_0000;
        1:       b32 = 32'h0;
        2:       b32 = $urandom_range(0, 15);
        default: b32 = $urandom;
      endcase
      exp32 = ref32(a32, b32, s);
      runOp32(a32, b32, s ? MULT : MULTU, res32, lat, ok);
      nCompared++;
      if (!ok || res32 !== exp32) begin
        nMismatched++;
        $display("[TB] FAIL rand32_%0d: a=%h b=%h s=%b got %h (done=%b) expected %h",
                 i, a32, b32, s, res32, ok, exp32);
      end
    end
    for (int i = 0; i < 500; i++) begin
      s    = 1'($urandom);
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      exp8 = ref8(a8, b8, s);
      runOp8(a8, b8, s ? MULT : MULTU, res8, lat, ok);
      nCompared++;
      if (!ok || res8 !== exp8) begin
        nMismatched++;
        $display("[TB] FAIL rand8_%0d: a=%h b=%h s=%b got %h (done=%b) expected %h",
                 i, a8, b8, s, res8, ok, exp8);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus32.start  = 1'b0;
    bus32.Signal = 6'd0;
    bus32.dataA  = '0;
    bus32.dataB  = '0;
    bus8.start   = 1'b0;
    bus8.Signal  = 6'd0;
    bus8.dataA   = '0;
    bus8.dataB   = '0;
    test_reset();
    test_bad_code();
    test_multu_basic();
    test_signed_corners();
    test_ignore_busy();
    test_back_to_back();
    test_reset_abort();
    test_width8();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
